// File: rtl/bdiv52x26_seq_if.sv
// Handshake bundle for the bdiv52x26_seq restoring divider.
// The master modport is the producer/consumer side; the slave modport is the divider.
interface bdiv52x26_seq_if #(
    parameter int WIDTH = 26
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   P;
    logic [WIDTH-1:0]     B;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     Q;
    logic [WIDTH-1:0]     R;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output in_valid, P, B, out_ready,
        input  in_ready, out_valid, Q, R, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, P, B, out_ready,
        output in_ready, out_valid, Q, R, div_by_zero, overflow
    );
endinterface

// File: rtl/bdiv52x26_seq.sv
// bdiv52x26_seq: sequential radix-2 restoring divider, 2*WIDTH-bit dividend by
// WIDTH-bit divisor, one quotient bit per clock, valid/ready on both sides.
// Optional feature: define BDIV_SELFCHECK_EN to add the check_err output, which
// re-multiplies the result and flags any mismatch against the captured dividend.
module bdiv52x26_seq #(
    parameter int WIDTH = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    bdiv52x26_seq_if.slave     bus
`ifdef BDIV_SELFCHECK_EN
    ,
    output logic               check_err
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     div_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 fast_q;
    logic                 fast_dbz_q;
    logic [WIDTH-1:0]     q_out_q;
    logic [WIDTH-1:0]     r_out_q;
    logic                 dbz_q;
    logic                 ovf_q;

    logic [WIDTH-1:0]     p_hi;
    logic [WIDTH-1:0]     p_lo;
    logic [WIDTH:0]       trial_d;
    logic                 trial_ge_d;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quo_d;

`ifdef BDIV_SELFCHECK_EN
    logic [2*WIDTH-1:0]   p_cap_q;
    logic                 check_err_q;
    logic [2*WIDTH:0]     recon_d;
    logic                 check_err_d;
`endif

    assign p_hi = bus.P[2*WIDTH-1:WIDTH];
    assign p_lo = bus.P[WIDTH-1:0];

    // One restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. Because the remainder always stays
    // below the divisor, the difference never needs more than WIDTH bits.
    always_comb begin
        trial_d    = {rem_q, quo_q[WIDTH-1]};
        trial_ge_d = (trial_d >= {1'b0, div_q});
        rem_d      = trial_ge_d ? (trial_d[WIDTH-1:0] - div_q) : trial_d[WIDTH-1:0];
        quo_d      = {quo_q[WIDTH-2:0], trial_ge_d};
    end

`ifdef BDIV_SELFCHECK_EN
    // Rebuild the dividend from the final quotient/remainder of the last step.
    always_comb begin
        recon_d     = (2*WIDTH+1)'(quo_d) * (2*WIDTH+1)'(div_q) + (2*WIDTH+1)'(rem_d);
        check_err_d = (recon_d != {1'b0, p_cap_q});
    end
`endif

    // Control FSM with registered handshake and result outputs. Fast-path
    // results (zero divisor, quotient overflow) spend one cycle in CALC so the
    // result appears one edge after the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            fast_q      <= 1'b0;
            fast_dbz_q  <= 1'b0;
            q_out_q     <= '0;
            r_out_q     <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef BDIV_SELFCHECK_EN
            p_cap_q     <= '0;
            check_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                        cnt_q      <= '0;
                        div_q      <= bus.B;
`ifdef BDIV_SELFCHECK_EN
                        p_cap_q    <= bus.P;
`endif
                        if (bus.B == '0) begin
                            fast_q     <= 1'b1;
                            fast_dbz_q <= 1'b1;
                            rem_q      <= '0;
                            quo_q      <= '1;
                        end else if (p_hi >= bus.B) begin
                            fast_q     <= 1'b1;
                            fast_dbz_q <= 1'b0;
                            rem_q      <= '0;
                            quo_q      <= '1;
                        end else begin
                            fast_q     <= 1'b0;
                            fast_dbz_q <= 1'b0;
                            rem_q      <= p_hi;
                            quo_q      <= p_lo;
                        end
                    end
                end
                CALC: begin
                    if (fast_q) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        q_out_q     <= quo_q;
                        r_out_q     <= rem_q;
                        dbz_q       <= fast_dbz_q;
                        ovf_q       <= !fast_dbz_q;
`ifdef BDIV_SELFCHECK_EN
                        check_err_q <= 1'b0;
`endif
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            q_out_q     <= quo_d;
                            r_out_q     <= rem_d;
                            dbz_q       <= 1'b0;
                            ovf_q       <= 1'b0;
`ifdef BDIV_SELFCHECK_EN
                            check_err_q <= check_err_d;
`endif
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        fast_q      <= 1'b0;
`ifdef BDIV_SELFCHECK_EN
                        check_err_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.Q           = q_out_q;
    assign bus.R           = r_out_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
`ifdef BDIV_SELFCHECK_EN
    assign check_err       = check_err_q;
`endif

endmodule

// File: tb/tb_bdiv52x26_seq.sv
// Self-checking bench for bdiv52x26_seq: directed vector table, backpressure and
// mid-operation reset sequences, and randomized operations against a model.
module tb_bdiv52x26_seq;

    localparam int W = 26;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

`ifdef BDIV_SELFCHECK_EN
    logic checkErr;
`endif

    bdiv52x26_seq_if #(.WIDTH(W)) bus ();

    bdiv52x26_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BDIV_SELFCHECK_EN
        ,
        .check_err (checkErr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] p;
        logic [W-1:0]   b;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dbz;
        logic           ovf;
        int             lat;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout required=response", name);
    endtask

    // Reference behaviour from the arithmetic definition of the divider.
    function automatic void refModel(input logic [2*W-1:0] p, input logic [W-1:0] b,
                                     output logic [W-1:0] q, output logic [W-1:0] r,
                                     output logic dbz, output logic ovf, output int lat);
        longint unsigned pl;
        longint unsigned bl;
        logic [W-1:0] hi;
        pl = 64'(p);
        bl = 64'(b);
        hi = p[2*W-1:W];
        if (b == '0) begin
            q = '1; r = '0; dbz = 1'b1; ovf = 1'b0; lat = 1;
        end else if (hi >= b) begin
            q = '1; r = '0; dbz = 1'b0; ovf = 1'b1; lat = 1;
        end else begin
            q = W'(pl / bl); r = W'(pl % bl); dbz = 1'b0; ovf = 1'b0; lat = W;
        end
    endfunction

    // Present one operation, wait for its accept, then count edges until out_valid.
    // Called and returns at #1 after a rising edge; leaves out_ready low.
    task automatic applyStimulus(input logic [2*W-1:0] p, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r,
                                 output logic dbz, output logic ovf, output logic chk,
                                 output int lat);
        int n;
        bus.P        = p;
        bus.B        = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.in_ready) reportTimeout("accept");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!bus.out_valid && lat < 100);
        if (!bus.out_valid) reportTimeout("result");
        q   = bus.Q;
        r   = bus.R;
        dbz = bus.div_by_zero;
        ovf = bus.overflow;
`ifdef BDIV_SELFCHECK_EN
        chk = checkErr;
`else
        chk = 1'b0;
`endif
    endtask

    // Complete the result handshake and confirm the block is idle with results held.
    task automatic finishHandshake(input string name, input logic [W-1:0] expQ, input logic [W-1:0] expR);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput({name, " out_valid after handshake"}, 64'(bus.out_valid), 64'd0);
        checkOutput({name, " in_ready after handshake"}, 64'(bus.in_ready), 64'd1);
        checkOutput({name, " Q held"}, 64'(bus.Q), 64'(expQ));
        checkOutput({name, " R held"}, 64'(bus.R), 64'(expR));
    endtask

    // Run one operation and compare everything against the given expectations.
    task automatic runOp(input string name, input logic [2*W-1:0] p, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input logic eovf, input int elat);
        logic [W-1:0] q, r;
        logic dbz, ovf, chk;
        int lat;
        applyStimulus(p, b, q, r, dbz, ovf, chk, lat);
        checkOutput({name, " Q"}, 64'(q), 64'(eq));
        checkOutput({name, " R"}, 64'(r), 64'(er));
        checkOutput({name, " div_by_zero"}, 64'(dbz), 64'(edbz));
        checkOutput({name, " overflow"}, 64'(ovf), 64'(eovf));
        checkOutput({name, " latency"}, 64'(lat), 64'(elat));
        if (!edbz && !eovf) begin
            checkOutput({name, " identity"}, 64'(q) * 64'(b) + 64'(r), 64'(p));
            checkOutput({name, " R<B"}, 64'(r < b), 64'd1);
        end
`ifdef BDIV_SELFCHECK_EN
        checkOutput({name, " check_err"}, 64'(chk), 64'd0);
`else
        if (chk) $display("[TB] unexpected check flag");
`endif
        finishHandshake(name, eq, er);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
        checkOutput({name, " out_valid"}, 64'(bus.out_valid), 64'd0);
        checkOutput({name, " Q"}, 64'(bus.Q), 64'd0);
        checkOutput({name, " R"}, 64'(bus.R), 64'd0);
        checkOutput({name, " div_by_zero"}, 64'(bus.div_by_zero), 64'd0);
        checkOutput({name, " overflow"}, 64'(bus.overflow), 64'd0);
`ifdef BDIV_SELFCHECK_EN
        checkOutput({name, " check_err"}, 64'(checkErr), 64'd0);
`endif
    endtask

    initial begin
        logic [W-1:0] q, r, mq, mr, b, hi, lo;
        logic dbz, ovf, chk, mdbz, movf;
        logic [2*W-1:0] p;
        int lat, mlat;
        logic seenValid;

        vecs[0] = '{52'd1000,           26'd7,          26'd142,        26'd6,          1'b0, 1'b0, 26};
        vecs[1] = '{52'hFFFFFF8000001,  26'h3FFFFFF,    26'h3FFFFFF,    26'd0,          1'b0, 1'b0, 26};
        vecs[2] = '{52'h123,            26'd0,          26'h3FFFFFF,    26'd0,          1'b1, 1'b0, 1};
        vecs[3] = '{52'h4000000,        26'd1,          26'h3FFFFFF,    26'd0,          1'b0, 1'b1, 1};
        vecs[4] = '{52'd50,             26'd6,          26'd8,          26'd2,          1'b0, 1'b0, 26};
        vecs[5] = '{52'd0,              26'd5,          26'd0,          26'd0,          1'b0, 1'b0, 26};
        vecs[6] = '{52'hFFFFFFBFFFFFF,  26'h3FFFFFF,    26'h3FFFFFF,    26'h3FFFFFE,    1'b0, 1'b0, 26};
        vecs[7] = '{52'h13FFFFFF,       26'd5,          26'h3FFFFFF,    26'd4,          1'b0, 1'b0, 26};
        vecs[8] = '{52'h14000000,       26'd5,          26'h3FFFFFF,    26'd0,          1'b0, 1'b1, 1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.P         = '0;
        bus.B         = '0;

        #2 rst_n = 1'b0;
        #1 checkResetValues("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].p, vecs[i].b, vecs[i].q, vecs[i].r,
                  vecs[i].dbz, vecs[i].ovf, vecs[i].lat);
        end

        // Backpressure: result held for 10 cycles, in_valid ignored, single handshake.
        applyStimulus(52'd1000, 26'd7, q, r, dbz, ovf, chk, lat);
        checkOutput("bp Q", 64'(q), 64'd142);
        checkOutput("bp R", 64'(r), 64'd6);
        for (int i = 0; i < 10; i++) begin
            bus.P        = 52'd50;
            bus.B        = 26'd6;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput("bp out_valid held", 64'(bus.out_valid), 64'd1);
            checkOutput("bp in_ready low", 64'(bus.in_ready), 64'd0);
            checkOutput("bp Q stable", 64'(bus.Q), 64'd142);
            checkOutput("bp R stable", 64'(bus.R), 64'd6);
        end
        bus.in_valid = 1'b0;
        finishHandshake("bp", 26'd142, 26'd6);
        @(posedge clk); #1;
        checkOutput("bp single handshake", 64'(bus.out_valid), 64'd0);
        checkOutput("bp idle", 64'(bus.in_ready), 64'd1);

        // Reset in the middle of an operation discards it.
        bus.P        = 52'd1000;
        bus.B        = 26'd7;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("midreset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        seenValid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seenValid = 1'b1;
        end
        checkOutput("midreset no out_valid", 64'(seenValid), 64'd0);
        runOp("after reset", 52'd50, 26'd6, 26'd8, 26'd2, 1'b0, 1'b0, 26);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 200; i++) begin
            if (i % 5 == 0) begin
                hi = W'($urandom_range(1, 32'h3FFFFFF));
                b  = (i % 10 == 0) ? '0 : W'($urandom_range(1, 32'(hi)));
            end else begin
                b  = W'($urandom_range(1, 32'h3FFFFFF));
                hi = W'($urandom % 32'(b));
            end
            lo = W'($urandom);
            p  = {hi, lo};
            refModel(p, b, mq, mr, mdbz, movf, mlat);
            runOp($sformatf("rand%0d", i), p, b, mq, mr, mdbz, movf, mlat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so a stuck handshake can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
